div_sequencer: RTL
==================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: none; operand width fixed at 32.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 dividend  input  32  numerator; latched on accepted start.
REQ-007 divisor  input  32  denominator; latched on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start through the DONE cycle.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  32  LO result; held until next accepted start.
REQ-011 remainder  output  32  HI result; held until next accepted start.
REQ-012 div_by_zero  output  1  set with done when divisor==0; held with results.
REQ-013 add_a, add_b  output  32 each  operands to the shared external 32-bit adder (rca32).
REQ-014 add_cin  output  1  adder carry-in.
REQ-015 add_sum  input  32, add_cout  input  1  adder result, combinational from add_a/add_b/add_cin in the same cycle.

Function
REQ-016 States SHALL be IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R, DONE.
REQ-017 IDLE: start=1 SHALL latch operands and signed_op; next state NEG_A if signed path, DONE if divisor==0, else ITER; start=0 SHALL stay IDLE.
REQ-018 start while not IDLE SHALL be ignored; operands not relatched.
REQ-019 ITER SHALL run exactly 32 cycles, 5-bit counter 0..31, exit to FIX_Q (signed path) or DONE.
REQ-020 Per ITER cycle: add_a={R[30:0],Q[31]}, add_b=~D, add_cin=1; if R[31]==1 or add_cout==1 then R<=add_sum, Q<={Q[30:0],1}; else R<={R[30:0],Q[31]}, Q<={Q[30:0],0}; R initialised 0, Q initialised to dividend.
REQ-021 Unsigned latency: start accepted at edge k -> done high in cycle k+33 (32 ITER + DONE).
REQ-022 DONE SHALL last one cycle, assert done, then return to IDLE.
REQ-023 Divide by zero: skip ITER; quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1, done in cycle k+1.
REQ-024 In IDLE and DONE, add_a, add_b, add_cin SHALL be driven 0.
REQ-025 div_by_zero SHALL clear on the next accepted start.

Reset
REQ-026 clear=1 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, adder outputs 0.
REQ-027 clear mid-operation SHALL abort with no done pulse; start in the same cycle as clear SHALL be ignored.

Configuration
REQ-028 Macro DIV_SIGNED_EN: when defined, signed_op=1 selects the signed path; when undefined, NEG_A/NEG_B/FIX_Q/FIX_R SHALL not exist, signed_op is ignored, all divides unsigned.
REQ-029 Signed path: NEG_A negates dividend via adder (~x + 1) if negative, else passes it; NEG_B likewise for divisor; both cycles always spent.
REQ-030 FIX_Q negates Q when sign(dividend)^sign(divisor)=1; FIX_R negates R when dividend negative; both cycles always spent.
REQ-031 Signed latency SHALL be k+37; signed divide-by-zero SHALL follow REQ-023 with raw dividend and k+1 latency.
REQ-032 -2^31 / -1 SHALL yield quotient 32'h8000_0000, remainder 0, div_by_zero=0.

Verification
REQ-033 Unsigned 100/7, start at edge k -> done at k+33, quotient=14, remainder=2.
REQ-034 Unsigned 32'hFFFF_FFFF/1 -> quotient=32'hFFFF_FFFF, remainder=0; adder driven 0 in IDLE/DONE.
REQ-035 Divisor 0, dividend 32'h1234 -> done at k+1, quotient=32'hFFFF_FFFF, remainder=32'h1234, div_by_zero=1.
REQ-036 With DIV_SIGNED_EN: -7/2 signed -> done at k+37, quotient=-3, remainder=-1; -2^31/-1 per REQ-032.
REQ-037 clear asserted in ITER cycle 10 -> no done, all outputs 0; start pulsed while busy -> no effect on result.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: 32-bit iterative restoring divider that borrows a shared
// external 32-bit adder (add_a/add_b/add_cin -> add_sum/add_cout).
// Unsigned divides take 32 ITER cycles plus one DONE cycle. Divide by zero
// bypasses ITER and reports quotient all-ones, remainder = dividend.
// Optional signed support is compiled in with the DIV_SIGNED_EN macro; it adds
// operand negation (NEG_A/NEG_B) before and result fixup (FIX_Q/FIX_R) after
// the unsigned core. Without the macro signed_op is ignored.
module div_sequencer (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX_Q,
        S_FIX_R,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_den;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_dbz;

    logic [31:0] w_quo_nxt;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_den_nxt;
    logic [31:0] w_shift;
    logic        w_accept;

`ifdef DIV_SIGNED_EN
    logic        r_signed;
    logic        r_neg_a;
    logic        r_neg_b;
    logic        w_neg_q;
`else
    logic        w_unused_signed_op;
    assign w_unused_signed_op = signed_op;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    // Remainder shifted left with the next dividend bit brought in from Q.
    assign w_shift  = {r_rem[30:0], r_quo[31]};

`ifdef DIV_SIGNED_EN
    assign w_neg_q  = r_neg_a ^ r_neg_b;
`endif

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, adder operand steering and next working-register values.
    always_comb begin
        w_state_nxt = r_state;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        w_quo_nxt   = r_quo;
        w_rem_nxt   = r_rem;
        w_den_nxt   = r_den;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_quo_nxt = dividend;
                    w_rem_nxt = '0;
                    w_den_nxt = divisor;
                    // Zero divisor wins over the signed path so the raw
                    // dividend is reported and latency stays one cycle.
                    if (divisor == '0) begin
                        w_quo_nxt   = '1;
                        w_rem_nxt   = dividend;
                        w_state_nxt = S_DONE;
`ifdef DIV_SIGNED_EN
                    end else if (signed_op) begin
                        w_state_nxt = S_NEG_A;
`endif
                    end else begin
                        w_state_nxt = S_ITER;
                    end
                end
            end

`ifdef DIV_SIGNED_EN
            S_NEG_A: begin
                add_a       = r_neg_a ? ~r_quo : r_quo;
                add_cin     = r_neg_a;
                w_quo_nxt   = add_sum;
                w_state_nxt = S_NEG_B;
            end

            S_NEG_B: begin
                add_a       = r_neg_b ? ~r_den : r_den;
                add_cin     = r_neg_b;
                w_den_nxt   = add_sum;
                w_state_nxt = S_ITER;
            end
`endif

            S_ITER: begin
                add_a   = w_shift;
                add_b   = ~r_den;
                add_cin = 1'b1;
                // R[31] set means the 33-bit shifted remainder already
                // exceeds any 32-bit divisor, so subtract regardless of carry.
                if (r_rem[31] || add_cout) begin
                    w_rem_nxt = add_sum;
                    w_quo_nxt = {r_quo[30:0], 1'b1};
                end else begin
                    w_rem_nxt = w_shift;
                    w_quo_nxt = {r_quo[30:0], 1'b0};
                end
                if (r_cnt == 5'd31) begin
`ifdef DIV_SIGNED_EN
                    w_state_nxt = r_signed ? S_FIX_Q : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            S_FIX_Q: begin
                add_a       = w_neg_q ? ~r_quo : r_quo;
                add_cin     = w_neg_q;
                w_quo_nxt   = add_sum;
                w_state_nxt = S_FIX_R;
            end

            S_FIX_R: begin
                add_a       = r_neg_a ? ~r_rem : r_rem;
                add_cin     = r_neg_a;
                w_rem_nxt   = add_sum;
                w_state_nxt = S_DONE;
            end
`endif

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working registers, iteration counter and held result registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_den       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_den <= w_den_nxt;

            if (r_state == S_ITER) begin
                r_cnt <= r_cnt + 5'd1;
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                r_dbz <= (divisor == '0);
            end

            // Results are captured on entry to DONE so they are valid with
            // the done pulse and held until the next operation completes.
            if (w_state_nxt == S_DONE) begin
                r_quotient  <= w_quo_nxt;
                r_remainder <= w_rem_nxt;
            end
        end
    end

`ifdef DIV_SIGNED_EN
    // Operand signs for the signed path, latched with an accepted start.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_signed <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
        end else if (w_accept) begin
            r_signed <= signed_op;
            r_neg_a  <= signed_op & dividend[31];
            r_neg_b  <= signed_op & divisor[31];
        end
    end
`endif

endmodule
